// File: rtl/single_mult.sv
// Bit-serial left-shift multiplier: consumes one multiplier bit per clock
// (LSB first) against a parallel multiplicand and publishes the 2N-bit
// product every N clocks, back-to-back with no idle cycles.
module single_mult #(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           x,
    input  logic [N-1:0]   Y,
    output logic [2*N-1:0] P,
    output logic [N:0]     count_out,
    output logic [2*N-1:0] temp_out
);

    logic [N:0]     count_q, count_d;
    logic [N-1:0]   y_q, y_d;
    logic [2*N-1:0] temp_q, temp_d;
    logic [2*N-1:0] p_q, p_d;

    logic           first_bit;
    logic           last_bit;
    logic [N-1:0]   operand;
    logic [2*N-1:0] addend;
    logic [2*N-1:0] base;
    logic [2*N-1:0] sum;

    // Next-state: accumulate the shifted multiplicand, publish on the last bit.
    always_comb begin
        count_d   = count_q;
        y_d       = y_q;
        temp_d    = temp_q;
        p_d       = p_q;

        first_bit = (count_q == '0);
        last_bit  = (count_q == (N+1)'(N-1));

        // Bit 0 uses the live Y (it is being captured this edge); later bits
        // use the latched copy so mid-operation changes on Y are ignored.
        operand   = first_bit ? Y : y_q;
        addend    = x ? ({{N{1'b0}}, operand} << count_q) : '0;
        base      = first_bit ? '0 : temp_q;
        sum       = base + addend;

        temp_d    = sum;
        if (first_bit) begin
            y_d = Y;
        end
        if (last_bit) begin
            p_d     = sum;
            count_d = '0;
        end else begin
            count_d = count_q + (N+1)'(1);
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            y_q     <= '0;
            temp_q  <= '0;
            p_q     <= '0;
        end else begin
            count_q <= count_d;
            y_q     <= y_d;
            temp_q  <= temp_d;
            p_q     <= p_d;
        end
    end

    assign P         = p_q;
    assign count_out = count_q;
    assign temp_out  = temp_q;

endmodule

// File: tb/tb_single_mult.sv
// Self-checking bench for single_mult: table of operations plus hand-written
// reset and basic-product sequences, with a product scoreboard queue.
module tb_single_mult;

    localparam int N = 6;

    logic           clk;
    logic           rst_n;
    logic           x;
    logic [N-1:0]   Y;
    logic [2*N-1:0] P;
    logic [N:0]     count_out;
    logic [2*N-1:0] temp_out;

    int errors = 0;
    int checks = 0;

    logic [2*N-1:0] sb[$];
    logic [2*N-1:0] p_hold;
    logic [2*N-1:0] m_temp;
    logic [N-1:0]   m_ylat;
    int             m_k;

    typedef struct {
        logic [N-1:0]   y;
        logic [N-1:0]   xb;
        int             ymid;
        int             midbit;
        logic [2*N-1:0] exp_p;
    } vec_t;

    vec_t vecs[6];

    single_mult #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .Y         (Y),
        .P         (P),
        .count_out (count_out),
        .temp_out  (temp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one bit, wait for the consuming edge, then check all outputs.
    task automatic step(input logic xb, input logic [N-1:0] yv);
        logic [2*N-1:0] exp_p;
        x = xb;
        Y = yv;
        @(posedge clk);
        #1;
        if (m_k == 0) begin
            m_ylat = yv;
            m_temp = xb ? {{N{1'b0}}, yv} : '0;
        end else if (xb) begin
            m_temp = m_temp + ({{N{1'b0}}, m_ylat} << m_k);
        end
        check("temp_out", temp_out, m_temp);
        if (m_k == N-1) begin
            check("count_wrap", {{(N-1){1'b0}}, count_out}, '0);
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard: got empty queue expected product");
            end else begin
                exp_p = sb.pop_front();
                check("product", P, exp_p);
                p_hold = exp_p;
            end
            m_k = 0;
        end else begin
            m_k++;
            check("count_step", {{(N-1){1'b0}}, count_out}, (2*N)'(m_k));
            check("p_hold", P, p_hold);
        end
    endtask

    task automatic run_op(input vec_t v);
        sb.push_back(v.exp_p);
        for (int i = 0; i < N; i++) begin
            if (v.ymid >= 0 && i >= v.midbit) step(v.xb[i], N'(v.ymid));
            else step(v.xb[i], v.y);
        end
    endtask

    // Assert reset mid-cycle, verify immediate and held clear, release at negedge.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_P", P, '0);
        check("rst_temp", temp_out, '0);
        check("rst_count", {{(N-1){1'b0}}, count_out}, '0);
        @(posedge clk);
        #1;
        check("rst_hold_P", P, '0);
        check("rst_hold_count", {{(N-1){1'b0}}, count_out}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        m_k = 0;
        m_temp = '0;
        p_hold = '0;
        sb.delete();
    endtask

    initial begin
        logic [2*N-1:0] basic_temp[N];
        logic [N-1:0]   basic_x;

        vecs[0] = '{y: 6'd63, xb: 6'b111111, ymid: -1, midbit: 0, exp_p: 12'd3969};
        vecs[1] = '{y: 6'd63, xb: 6'b000000, ymid: -1, midbit: 0, exp_p: 12'd0};
        vecs[2] = '{y: 6'd13, xb: 6'b101101, ymid: -1, midbit: 0, exp_p: 12'd585};
        vecs[3] = '{y: 6'd1,  xb: 6'b111111, ymid: -1, midbit: 0, exp_p: 12'd63};
        vecs[4] = '{y: 6'd0,  xb: 6'b010101, ymid: -1, midbit: 0, exp_p: 12'd0};
        vecs[5] = '{y: 6'd5,  xb: 6'b111111, ymid: 60, midbit: 3, exp_p: 12'd315};

        basic_temp[0] = 12'd0;
        basic_temp[1] = 12'd0;
        basic_temp[2] = 12'd0;
        basic_temp[3] = 12'd104;
        basic_temp[4] = 12'd104;
        basic_temp[5] = 12'd520;
        basic_x = 6'b101000;

        rst_n = 1'b1;
        x = 1'b0;
        Y = '0;
        m_k = 0;
        m_temp = '0;
        m_ylat = '0;
        p_hold = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Basic product 13 * 40 with the literal temp sequence.
        sb.push_back(12'd520);
        for (int i = 0; i < N; i++) begin
            step(basic_x[i], 6'd13);
            check("basic_temp_seq", temp_out, basic_temp[i]);
        end

        // Table: extremes, back-to-back, mid-operation Y change.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i]);
        end

        // Reset partway through an operation, then a clean operation.
        step(1'b1, 6'd9);
        step(1'b1, 6'd9);
        step(1'b1, 6'd9);
        do_reset();
        run_op('{y: 6'd7, xb: 6'b000011, ymid: -1, midbit: 0, exp_p: 12'd21});
        check("post_rst_count", {{(N-1){1'b0}}, count_out}, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
